ras_ckpt: RTL

//   Parametrised return address stack (RAS) with checkpoint/restore, used by the front-end branch predictor.

---
 rtl/ras_ckpt_if.sv | 32 +++
 rtl/ras_ckpt.sv | 66 ++++++
 2 files changed

// File: rtl/ras_ckpt_if.sv
// Return-address-stack port bundle: call/return stream, checkpoint outputs and restore inputs.
// master drives push/pop/restore and reads the TOS/checkpoint; slave is the stack itself.
interface ras_ckpt_if #(
  parameter int RAS_DEPTH        = 8,
  parameter int LOG_RAS_DEPTH    = $clog2(RAS_DEPTH),
  parameter int RAS_TARGET_WIDTH = 12
);
  logic                        push_valid;
  logic [RAS_TARGET_WIDTH-1:0] push_target;
  logic                        pop_valid;
  logic [RAS_TARGET_WIDTH-1:0] pop_target;
  logic                        pop_empty;
  logic [LOG_RAS_DEPTH-1:0]    ras_index;
  logic [LOG_RAS_DEPTH:0]      ras_count;
  logic                        restore_valid;
  logic [LOG_RAS_DEPTH-1:0]    restore_index;
  logic [LOG_RAS_DEPTH:0]      restore_count;
  logic                        restore_write;
  logic [RAS_TARGET_WIDTH-1:0] restore_target;

  modport master (
    output push_valid, push_target, pop_valid,
           restore_valid, restore_index, restore_count, restore_write, restore_target,
    input  pop_target, pop_empty, ras_index, ras_count
  );

  modport slave (
    input  push_valid, push_target, pop_valid,
           restore_valid, restore_index, restore_count, restore_write, restore_target,
    output pop_target, pop_empty, ras_index, ras_count
  );
endinterface

// File: rtl/ras_ckpt.sv
// Circular return address stack with {index,count} checkpoint restore and optional TOS repair.
// TOS readable in the same cycle (0-cycle read), updates visible next cycle; never stalls, overflow drops oldest.
module ras_ckpt #(
  parameter int RAS_DEPTH        = 8,
  parameter int LOG_RAS_DEPTH    = $clog2(RAS_DEPTH),
  parameter int RAS_TARGET_WIDTH = 12
) (
  input logic       CLK,
  input logic       nRST,
  ras_ckpt_if.slave ras
);
  localparam logic [LOG_RAS_DEPTH:0] FULL = (LOG_RAS_DEPTH+1)'(RAS_DEPTH);

  logic [RAS_TARGET_WIDTH-1:0] stack [RAS_DEPTH];
  logic [LOG_RAS_DEPTH-1:0]    idx, idx_nxt, wr_addr;
  logic [LOG_RAS_DEPTH:0]      cnt, cnt_nxt;
  logic                        wr_en;
  logic [RAS_TARGET_WIDTH-1:0] wr_dat;

  always_comb begin
    idx_nxt = idx;
    cnt_nxt = cnt;
    wr_en   = 1'b0;
    wr_addr = idx;
    wr_dat  = ras.push_target;
    if (ras.restore_valid) begin
      idx_nxt = ras.restore_index;
      cnt_nxt = ras.restore_count;
      wr_en   = ras.restore_write;
      wr_addr = ras.restore_index;
      wr_dat  = ras.restore_target;
    end else if (ras.push_valid && ras.pop_valid) begin
      // Return-then-call: replace TOS in place.
      wr_en = 1'b1;
      if (cnt == '0) cnt_nxt = 1;
    end else if (ras.push_valid) begin
      idx_nxt = idx + 1'b1;
      wr_en   = 1'b1;
      wr_addr = idx + 1'b1;
      cnt_nxt = (cnt == FULL) ? cnt : cnt + 1'b1;
    end else if (ras.pop_valid && cnt != '0) begin
      idx_nxt = idx - 1'b1;
      cnt_nxt = cnt - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < RAS_DEPTH; i++) stack[i] <= '0;
      idx <= '0;
      cnt <= '0;
    end else begin
      idx <= idx_nxt;
      cnt <= cnt_nxt;
      if (wr_en) stack[wr_addr] <= wr_dat;
    end
  end

  assign ras.pop_target = stack[idx];
  assign ras.ras_index  = idx;
  assign ras.ras_count  = cnt;
  assign ras.pop_empty  = (cnt == '0);

  ras_restore_count_legal: assert property (
    @(posedge CLK) disable iff (!nRST) ras.restore_valid |-> (ras.restore_count <= FULL));
endmodule
